// File: rtl/hv_iso_rx.sv
// hv_iso_rx: HV-side receiver for the isolated single-wire command link (oversampled, CRC-8, stop check).
// Optional link-loss timeout enabled by defining HV_RX_TMO_EN.
`default_nettype none

module hv_iso_rx #(
  parameter int OVS     = 8,
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iso_rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_vld,
  output logic              crc_err,
  output logic              frm_err,
  output logic              rx_busy,
  output logic              link_lost
);

  localparam int CNT_W = $clog2(OVS);
  localparam int IDX_W = $clog2(DATA_W + 8);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    CRC   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              sync1, rxd_s, rxd_d, armed;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] data_sr;
  logic [7:0]        crc_rx, crc_calc, crc_step;
  logic              fall, samp, start_samp, state_chg;

  assign fall       = rxd_d & ~rxd_s;
  assign samp       = (bit_cnt == CNT_W'(OVS - 1));
  assign start_samp = (bit_cnt == CNT_W'(OVS / 2 - 1));
  assign state_chg  = (state_nxt != state);
  assign rx_busy    = (state != IDLE);
  assign crc_step   = {crc_calc[6:0], 1'b0} ^ ((crc_calc[7] ^ rxd_s) ? 8'h07 : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      sync1 <= iso_rxd;
      rxd_s <= sync1;
      rxd_d <= rxd_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (armed && fall) state_nxt = START;
      START:   if (start_samp) state_nxt = rxd_s ? IDLE : DATA;
      DATA:    if (samp && bit_idx == IDX_W'(DATA_W - 1)) state_nxt = CRC;
      CRC:     if (samp && bit_idx == IDX_W'(7)) state_nxt = STOP;
      STOP:    if (samp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing: counters restart on every state change so each phase measures from its own entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      bit_idx <= '0;
    end else if (state_chg || state == IDLE) begin
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      bit_cnt <= samp ? '0 : bit_cnt + 1'b1;
      if (samp && (state == DATA || state == CRC)) bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sr  <= '0;
      crc_rx   <= '0;
      crc_calc <= '0;
      rx_data  <= '0;
      rx_vld   <= 1'b0;
      crc_err  <= 1'b0;
      frm_err  <= 1'b0;
      armed    <= 1'b1;
    end else begin
      rx_vld  <= 1'b0;
      crc_err <= 1'b0;
      frm_err <= 1'b0;
      if (rxd_s) armed <= 1'b1;
      if (state == IDLE && fall) crc_calc <= '0;
      if (samp) begin
        case (state)
          DATA: begin
            data_sr  <= {data_sr[DATA_W-2:0], rxd_s};
            crc_calc <= crc_step;
          end
          CRC: crc_rx <= {crc_rx[6:0], rxd_s};
          STOP: begin
            // Disarm after a bad stop so a stuck-low line reports only once.
            if (!rxd_s) begin
              frm_err <= 1'b1;
              armed   <= 1'b0;
            end else if (crc_rx == crc_calc) begin
              rx_data <= data_sr;
              rx_vld  <= 1'b1;
            end else begin
              crc_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef HV_RX_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt   <= '0;
      link_lost <= 1'b0;
    end else if (rx_vld) begin
      tmo_cnt   <= '0;
      link_lost <= 1'b0;
    end else if (tmo_cnt != TMO_W'(TMO_CYC - 1)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_cnt == TMO_W'(TMO_CYC - 2)) link_lost <= 1'b1;
    end
  end
`else
  assign link_lost = 1'b0;
`endif

endmodule

`default_nettype wire
